// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the write-back path: register-file geometry,
// the hard-wired zero register and the two-way grant encoding.
package cpu_pkg;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    // One-hot grant: bit 0 = requester A, bit 1 = requester B.
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_A    = 2'b01,
        GNT_B    = 2'b10
    } gnt_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Two-way combinational picker: one-hot (or zero) grant from a request pair,
// round-robin on contention when fair is set, otherwise A-first.
module wb_rr_pick
    import cpu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_b,
    input  logic       fair,
    output logic [1:0] gnt
);

    gnt_t pick;

    always_comb begin
        pick = GNT_NONE;
        unique case (req)
            2'b01:   pick = GNT_A;
            2'b10:   pick = GNT_B;
            2'b11:   pick = (fair && !last_b) ? GNT_B : GNT_A;
            default: pick = GNT_NONE;
        endcase
    end

    assign gnt = pick;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the ALU/load path (A)
// and the multi-cycle unit (B); registered write-port outputs, one cycle latency.
module wb_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned DW   = cpu_pkg::DW,
    parameter int unsigned AW   = cpu_pkg::AW,
    parameter bit          FAIR = 1'b1,
    parameter int unsigned CW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    input  logic          rf_hold,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          last_b,
    output logic [CW-1:0] conflicts
);

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          xfer;
    logic          contend;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    // Masking requests during reset/hold keeps both readies low, so nothing
    // granted in a reset cycle can be lost by the requester.
    assign req = (rst || rf_hold) ? 2'b00 : {b_valid, a_valid};

    wb_rr_pick u_pick (
        .req    (req),
        .last_b (last_b),
        .fair   (FAIR),
        .gnt    (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];
    assign xfer    = a_ready || b_ready;
    assign contend = a_valid && b_valid && !rf_hold;

    always_comb begin
        win_addr = a_addr;
        win_data = a_data;
        if (b_ready) begin
            win_addr = b_addr;
            win_data = b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            last_b    <= 1'b1;
            conflicts <= '0;
        end else begin
            // Writes to the zero register still complete and load the
            // address/data registers, but never raise the write enable.
            rf_we <= xfer && (win_addr != AW'(REG_ZERO));
            if (xfer) begin
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
                last_b   <= b_ready;
            end
            if (contend && (conflicts != '1)) begin
                conflicts <= conflicts + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a round-robin instance (narrow
// counter) and a fixed-priority instance share stimulus against a behavioural model.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, rf_hold;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;

    logic        o_a_ready [2];
    logic        o_b_ready [2];
    logic        o_we      [2];
    logic [4:0]  o_waddr   [2];
    logic [31:0] o_wdata   [2];
    logic        o_last_b  [2];
    logic [3:0]  r_conf;
    logic [15:0] f_conf;

    int unsigned total  = 0;
    int unsigned passed = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DW(32), .AW(5), .FAIR(1'b1), .CW(4)) dut_rr (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(o_a_ready[0]), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(o_b_ready[0]), .b_addr(b_addr), .b_data(b_data),
        .rf_hold(rf_hold), .rf_we(o_we[0]), .rf_waddr(o_waddr[0]), .rf_wdata(o_wdata[0]),
        .last_b(o_last_b[0]), .conflicts(r_conf)
    );

    wb_port_arbiter #(.DW(32), .AW(5), .FAIR(1'b0), .CW(16)) dut_fx (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(o_a_ready[1]), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(o_b_ready[1]), .b_addr(b_addr), .b_data(b_data),
        .rf_hold(rf_hold), .rf_we(o_we[1]), .rf_waddr(o_waddr[1]), .rf_wdata(o_wdata[1]),
        .last_b(o_last_b[1]), .conflicts(f_conf)
    );

    // ---------------- behavioural model (index 0 = round-robin, 1 = fixed) ----
    logic        m_we    [2];
    logic [4:0]  m_waddr [2];
    logic [31:0] m_wdata [2];
    logic        m_lastb [2];
    int unsigned m_conf  [2];
    int unsigned conf_max [2] = '{15, 65535};
    bit          is_fair  [2] = '{1'b1, 1'b0};

    // 0 = nobody, 1 = A, 2 = B
    function automatic int winner(bit rs, bit hold, bit av, bit bv, bit fair, bit lb);
        if (rs || hold) return 0;
        if (av && bv) return (fair && !lb) ? 2 : 1;
        if (av) return 1;
        if (bv) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int w;
            w = winner(rst, rf_hold, a_valid, b_valid, is_fair[k], m_lastb[k]);
            if (rst) begin
                m_we[k]    <= 1'b0;
                m_waddr[k] <= '0;
                m_wdata[k] <= '0;
                m_lastb[k] <= 1'b1;
                m_conf[k]  <= 0;
            end else begin
                m_we[k] <= (w == 1 && a_addr != 0) || (w == 2 && b_addr != 0);
                if (w == 1) begin
                    m_waddr[k] <= a_addr;
                    m_wdata[k] <= a_data;
                    m_lastb[k] <= 1'b0;
                end else if (w == 2) begin
                    m_waddr[k] <= b_addr;
                    m_wdata[k] <= b_data;
                    m_lastb[k] <= 1'b1;
                end
                if (a_valid && b_valid && !rf_hold && m_conf[k] < conf_max[k])
                    m_conf[k] <= m_conf[k] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                int w;
                logic [31:0] conf_act;
                w = winner(rst, rf_hold, a_valid, b_valid, is_fair[k], m_lastb[k]);
                conf_act = (k == 0) ? 32'(r_conf) : 32'(f_conf);
                check($sformatf("cyc%0d.a_ready", k), 32'(o_a_ready[k]), 32'(w == 1));
                check($sformatf("cyc%0d.b_ready", k), 32'(o_b_ready[k]), 32'(w == 2));
                check($sformatf("cyc%0d.rf_we", k),   32'(o_we[k]),      32'(m_we[k]));
                check($sformatf("cyc%0d.rf_waddr", k), 32'(o_waddr[k]),  32'(m_waddr[k]));
                check($sformatf("cyc%0d.rf_wdata", k), o_wdata[k],       m_wdata[k]);
                check($sformatf("cyc%0d.last_b", k),  32'(o_last_b[k]),  32'(m_lastb[k]));
                check($sformatf("cyc%0d.conflicts", k), conf_act,        m_conf[k]);
            end
        end
    end

    // ---------------- directed stimulus with literal expectations -------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0;
        b_valid = 1'b0;
        rf_hold = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
        step();
        chk_en = 1'b1;
        step();
        @(negedge clk);
        check("rst.rf_we",     32'(o_we[0]),     32'd0);
        check("rst.rf_waddr",  32'(o_waddr[0]),  32'd0);
        check("rst.rf_wdata",  o_wdata[0],       32'd0);
        check("rst.last_b",    32'(o_last_b[0]), 32'd1);
        check("rst.conflicts", 32'(r_conf),      32'd0);
        rst = 1'b0;
        step();

        // Only A
        a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h1234;
        @(negedge clk);
        check("onlyA.a_ready", 32'(o_a_ready[0]), 32'd1);
        step();
        idle();
        @(negedge clk);
        check("onlyA.rf_we",    32'(o_we[0]),    32'd1);
        check("onlyA.rf_waddr", 32'(o_waddr[0]), 32'd8);
        check("onlyA.rf_wdata", o_wdata[0],      32'h1234);

        // Contention, round-robin vs fixed priority
        do_reset();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA1;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rr%0d.a_ready", i), 32'(o_a_ready[0]), 32'(i % 2 == 0));
            check($sformatf("rr%0d.b_ready", i), 32'(o_b_ready[0]), 32'(i % 2 == 1));
            check($sformatf("fx%0d.b_ready", i), 32'(o_b_ready[1]), 32'd0);
            if (i > 0) check($sformatf("rr%0d.rf_we", i), 32'(o_we[0]), 32'd1);
            step();
        end
        idle();
        @(negedge clk);
        check("rr.rf_we_last",  32'(o_we[0]),    32'd1);
        check("rr.waddr_last",  32'(o_waddr[0]), 32'd2);
        check("rr.conflicts",   32'(r_conf),     32'd4);
        check("fx.conflicts",   32'(f_conf),     32'd4);
        check("fx.waddr_last",  32'(o_waddr[1]), 32'd1);
        step();
        @(negedge clk);
        check("rr.rf_we_after", 32'(o_we[0]),    32'd0);

        // Write to register zero
        do_reset();
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h55;
        @(negedge clk);
        check("r0.a_ready", 32'(o_a_ready[0]), 32'd1);
        step();
        a_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h77;
        @(negedge clk);
        check("r0.rf_we",    32'(o_we[0]),     32'd0);
        check("r0.rf_waddr", 32'(o_waddr[0]),  32'd0);
        check("r0.rf_wdata", o_wdata[0],       32'h55);
        check("r0.last_b",   32'(o_last_b[0]), 32'd0);
        check("r0.b_ready",  32'(o_b_ready[0]), 32'd1);
        step();
        idle();
        @(negedge clk);
        check("r0.b_we",    32'(o_we[0]),    32'd1);
        check("r0.b_waddr", 32'(o_waddr[0]), 32'd3);

        // Hold with both valid
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h44;
        b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h66;
        rf_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d.a_ready", i), 32'(o_a_ready[0]), 32'd0);
            check($sformatf("hold%0d.b_ready", i), 32'(o_b_ready[0]), 32'd0);
            check($sformatf("hold%0d.rf_we", i),   32'(o_we[0]),      32'd0);
            check($sformatf("hold%0d.conf", i),    32'(r_conf),       32'd0);
            step();
        end
        rf_hold = 1'b0;
        @(negedge clk);
        check("rel.a_ready", 32'(o_a_ready[0]), 32'd1);
        check("rel.conf",    32'(r_conf),       32'd0);
        step();
        a_valid = 1'b0;
        @(negedge clk);
        check("rel.rf_waddr", 32'(o_waddr[0]), 32'd4);
        check("rel.conf1",    32'(r_conf),     32'd1);
        check("rel.b_ready",  32'(o_b_ready[0]), 32'd1);
        step();
        idle();

        // Reset arriving while a request would be granted
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h60;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h70;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid.a_ready", 32'(o_a_ready[0]), 32'd0);
        check("rstmid.b_ready", 32'(o_b_ready[0]), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid.rf_we",   32'(o_we[0]),      32'd0);
        check("rstmid.wdata",   o_wdata[0],        32'd0);
        check("rstmid.last_b",  32'(o_last_b[0]),  32'd1);
        check("rstmid.conf",    32'(r_conf),       32'd0);
        check("rstmid.a_first", 32'(o_a_ready[0]), 32'd1);
        step();
        idle();

        // Same destination from both: later grant (B) is last written
        do_reset();
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h22;
        step();
        a_valid = 1'b0;
        step();
        idle();
        @(negedge clk);
        check("same.rf_waddr", 32'(o_waddr[0]), 32'd9);
        check("same.rf_wdata", o_wdata[0],      32'h22);

        // Counter saturation on the narrow instance
        do_reset();
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hAA;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hBB;
        repeat (20) step();
        idle();
        @(negedge clk);
        check("sat.rr_conf", 32'(r_conf), 32'd15);
        check("sat.fx_conf", 32'(f_conf), 32'd20);
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
